// File: rtl/sap1_pkg.sv
// Shared SAP-1 datapath types.
// Bus width and data word used by A, B, ALU and output register.
package sap1_pkg;

    localparam int DATA_W = 8;

    typedef logic [DATA_W-1:0] data_t;

endpackage

// File: rtl/load_reg.sv
// Generic load-enabled register with asynchronous reset.
// Reused by register A, register B and the output register.
module load_reg #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RESET_VAL;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/reg_a.sv
// SAP-1 accumulator register A.
// Feeds the ALU, optionally drives the bus, and reports zero/neg flags.
module reg_a
    import sap1_pkg::*;
#(
    parameter int               WIDTH     = DATA_W,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] bus,
    output logic [WIDTH-1:0] out,
    input  logic             en_out,
    output logic [WIDTH-1:0] bus_drv,
    output logic             bus_drv_valid,
    output logic             zero,
    output logic             neg
);

    logic [WIDTH-1:0] q;

    load_reg #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
    ) u_reg (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .d    (bus),
        .q    (q)
    );

    // Flags come from the stored value only, so bus glitches never reach them.
    assign out           = q;
    assign zero          = (q == '0);
    assign neg           = q[WIDTH-1];
    assign bus_drv       = q & {WIDTH{en_out}};
    assign bus_drv_valid = en_out;

endmodule

// File: tb/tb_reg_a.sv
// Directed testbench for reg_a.
module tb_reg_a;

    logic       clk;
    logic       rst;
    logic       load;
    logic [7:0] bus;
    logic [7:0] out;
    logic       en_out;
    logic [7:0] bus_drv;
    logic       bus_drv_valid;
    logic       zero;
    logic       neg;

    int vectors;
    int miscompares;

    reg_a dut (
        .clk           (clk),
        .rst           (rst),
        .load          (load),
        .bus           (bus),
        .out           (out),
        .en_out        (en_out),
        .bus_drv       (bus_drv),
        .bus_drv_valid (bus_drv_valid),
        .zero          (zero),
        .neg           (neg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1; load = 1'b0; bus = 8'h00; en_out = 1'b0;
        #10;
        vectors++;
        if (out !== 8'd0 || zero !== 1'b1 || neg !== 1'b0) begin
            miscompares++;
            $display("FAIL reset: out=%0d zero=%b neg=%b want out=0 zero=1 neg=0",
                     out, zero, neg);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (out !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_release: out=%0d want 0", out);
        end
    endtask

    task automatic test_loads();
        logic [7:0] vals [4] = '{8'd64, 8'd56, 8'd94, 8'd255};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            load = 1'b1; bus = vals[i];
            @(posedge clk); #1;
            vectors++;
            if (out !== vals[i]) begin
                miscompares++;
                $display("FAIL load%0d: out=%0d want %0d", i, out, vals[i]);
            end
        end
        vectors++;
        if (neg !== 1'b1 || zero !== 1'b0) begin
            miscompares++;
            $display("FAIL flags_255: zero=%b neg=%b want zero=0 neg=1", zero, neg);
        end
    endtask

    task automatic test_hold();
        @(negedge clk);
        load = 1'b0; bus = 8'd100;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            bus = bus + 8'd7;
            #1;
            vectors++;
            if (out !== 8'd255) begin
                miscompares++;
                $display("FAIL hold%0d: out=%0d want 255", i, out);
            end
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (out !== 8'd0 || zero !== 1'b1) begin
            miscompares++;
            $display("FAIL async_rst: out=%0d zero=%b want out=0 zero=1", out, zero);
        end
        load = 1'b1; bus = 8'd77;
        @(posedge clk); #1;
        vectors++;
        if (out !== 8'd0) begin
            miscompares++;
            $display("FAIL load_in_rst: out=%0d want 0", out);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (out !== 8'd77) begin
            miscompares++;
            $display("FAIL release_load: out=%0d want 77", out);
        end
    endtask

    task automatic test_bus_drive();
        @(negedge clk);
        load = 1'b1; bus = 8'h5A; en_out = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (bus_drv !== 8'h00 || bus_drv_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL drv_idle: bus_drv=%h valid=%b want 00 0",
                     bus_drv, bus_drv_valid);
        end
        load = 1'b0; en_out = 1'b1;
        #1;
        vectors++;
        if (bus_drv !== 8'h5A || bus_drv_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL drv_on: bus_drv=%h valid=%b want 5a 1",
                     bus_drv, bus_drv_valid);
        end
        en_out = 1'b0;
        #1;
        vectors++;
        if (bus_drv !== 8'h00 || bus_drv_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL drv_off: bus_drv=%h valid=%b want 00 0",
                     bus_drv, bus_drv_valid);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        load = 1'b1; bus = 8'h11; en_out = 1'b0;
        @(negedge clk);
        en_out = 1'b1; load = 1'b1; bus = 8'h22;
        #1;
        vectors++;
        if (bus_drv !== 8'h11) begin
            miscompares++;
            $display("FAIL sim_before: bus_drv=%h want 11", bus_drv);
        end
        @(posedge clk); #1;
        vectors++;
        if (bus_drv !== 8'h22 || out !== 8'h22) begin
            miscompares++;
            $display("FAIL sim_after: bus_drv=%h out=%h want 22 22", bus_drv, out);
        end
        @(negedge clk);
        load = 1'b0; en_out = 1'b0; bus = 8'h00;
        @(posedge clk); #1;
        vectors++;
        if (out !== 8'h22 || zero !== 1'b0 || neg !== 1'b0) begin
            miscompares++;
            $display("FAIL final_hold: out=%h zero=%b neg=%b want 22 0 0",
                     out, zero, neg);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_loads();
        test_hold();
        test_async_reset();
        test_bus_drive();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
